// File: rtl/ulpi_reg_access.sv
// Link-side ULPI register write/read engine: issues TX CMD, handshakes nxt/stp, honours dir turnaround.
// Read path is built only when ULPI_REG_READ_EN is defined; otherwise reads are rejected with err=1.
module ulpi_reg_access #(
  parameter int NXT_TIMEOUT = 255
) (
  input  logic       clk_ulpi,
  input  logic       rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic       resp_err,
  output logic [7:0] resp_rdata
);

  typedef enum logic [2:0] {
    IDLE, CMD, WDATA, STP, ABORT
`ifdef ULPI_REG_READ_EN
    , RD_TURN, RD_DATA, RD_END
`endif
  } state_t;

  localparam logic [7:0] TMO = 8'(NXT_TIMEOUT);

  state_t     state;
  logic       dir_q;
  logic [7:0] cnt;
  logic       wr_q;
  logic [5:0] addr_q;
  logic [7:0] wdata_q;
  logic       err_q;
  logic       owned;
  logic       timeout;

`ifdef ULPI_REG_READ_EN
  logic [7:0] rdata_q;
`else
  logic       unused_data_i;
  assign unused_data_i = ^ulpi_data_i;
`endif

  // Ownership follows dir combinationally so the pad is released the same cycle dir rises.
  assign owned        = !ulpi_dir && !dir_q;
  assign ulpi_data_oe = owned && !rst;
  assign req_ready    = owned && !rst && (state == IDLE) && !resp_valid;
  assign ulpi_stp     = (state == STP);
  assign timeout      = ((cnt + 8'd1) == TMO);

  always_comb begin
    ulpi_data_o = '0;
    case (state)
      CMD:     ulpi_data_o = {1'b1, ~wr_q, addr_q};
      WDATA:   ulpi_data_o = wdata_q;
      default: ulpi_data_o = '0;
    endcase
  end

  always_ff @(posedge clk_ulpi) begin
    if (rst) begin
      state      <= IDLE;
      dir_q      <= 1'b1;
      cnt        <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
`ifdef ULPI_REG_READ_EN
      rdata_q    <= '0;
`endif
    end else begin
      dir_q      <= ulpi_dir;
      resp_valid <= 1'b0;
      cnt        <= '0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= 1'b0;
`ifdef ULPI_REG_READ_EN
            state   <= CMD;
`else
            if (req_write) begin
              state <= CMD;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end
`endif
          end
        end
        CMD: begin
          // A read sees dir+nxt together as the PHY accepting the command; anything else with dir is an abort.
          if (ulpi_dir && !(ulpi_nxt && !wr_q)) begin
            state <= ABORT;
          end else if (ulpi_nxt) begin
`ifdef ULPI_REG_READ_EN
            state <= wr_q ? WDATA : RD_TURN;
`else
            state <= WDATA;
`endif
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= STP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WDATA: begin
          if (ulpi_dir) begin
            state <= ABORT;
          end else if (ulpi_nxt) begin
            state <= STP;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= STP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STP: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          state      <= IDLE;
        end
        ABORT: begin
          if (!ulpi_dir) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= IDLE;
          end
        end
`ifdef ULPI_REG_READ_EN
        RD_TURN: begin
          if (ulpi_dir) begin
            state <= RD_DATA;
          end else if (timeout) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RD_DATA: begin
          if (ulpi_dir && dir_q) begin
            rdata_q <= ulpi_data_i;
            state   <= RD_END;
          end else if (!ulpi_dir) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state      <= IDLE;
          end
        end
        RD_END: begin
          if (!ulpi_dir) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= rdata_q;
            state      <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed + randomized bench for ulpi_reg_access with a transaction-level model of the PHY bus.
// Expectations for reads follow ULPI_REG_READ_EN.
module tb_ulpi_reg_access;

  localparam int TMO = 4;

  logic       clk_ulpi = 1'b0;
  logic       rst;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe;
  logic       ulpi_stp;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic       resp_err;
  logic [7:0] resp_rdata;

  int tests = 0;
  int fails = 0;
  logic [7:0] model_rdata = 8'h00;

  ulpi_reg_access #(.NXT_TIMEOUT(TMO)) dut (
    .clk_ulpi    (clk_ulpi),
    .rst         (rst),
    .ulpi_dir    (ulpi_dir),
    .ulpi_nxt    (ulpi_nxt),
    .ulpi_data_i (ulpi_data_i),
    .ulpi_data_o (ulpi_data_o),
    .ulpi_data_oe(ulpi_data_oe),
    .ulpi_stp    (ulpi_stp),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata)
  );

  always #5 clk_ulpi = ~clk_ulpi;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_ulpi);
    @(negedge clk_ulpi);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TX CMD byte: 10aaaaaa for RegWrite, 11aaaaaa for RegRead.
  function automatic logic [7:0] cmd_byte(input bit wr, input logic [5:0] a);
    return 8'h80 + (wr ? 8'd0 : 8'd64) + {2'b00, a};
  endfunction

  task automatic check_resp(input logic exp_err);
    chk("resp_valid", {7'd0, resp_valid}, 8'd1);
    chk("resp_err", {7'd0, resp_err}, {7'd0, exp_err});
    chk("resp_rdata", resp_rdata, model_rdata);
    chk("stp_at_resp", {7'd0, ulpi_stp}, 8'd0);
    chk("ready_at_resp", {7'd0, req_ready}, 8'd0);
    step();
    chk("resp_pulse_end", {7'd0, resp_valid}, 8'd0);
    chk("ready_after_resp", {7'd0, req_ready}, 8'd1);
  endtask

  task automatic issue(input bit wr, input logic [5:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    chk("ready_before_req", {7'd0, req_ready}, 8'd1);
    step();
    req_valid = 1'b0; req_wdata = 8'($urandom); req_addr = 6'($urandom);
  endtask

  task automatic cmd_phase(input bit wr, input logic [5:0] a, input int unsigned dc);
    for (int unsigned i = 0; i <= dc; i++) begin
      chk("cmd_byte", ulpi_data_o, cmd_byte(wr, a));
      chk("cmd_oe", {7'd0, ulpi_data_oe}, 8'd1);
      ulpi_nxt = (i == dc);
      step();
    end
    ulpi_nxt = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d,
                          input int unsigned dc, input int unsigned dw);
    issue(1'b1, a, d);
    cmd_phase(1'b1, a, dc);
    for (int unsigned i = 0; i <= dw; i++) begin
      chk("wdata_byte", ulpi_data_o, d);
      chk("wdata_stp", {7'd0, ulpi_stp}, 8'd0);
      ulpi_nxt = (i == dw);
      step();
    end
    ulpi_nxt = 1'b0;
    chk("stp_pulse", {7'd0, ulpi_stp}, 8'd1);
    chk("stp_noop", ulpi_data_o, 8'h00);
    step();
    check_resp(1'b0);
  endtask

  task automatic do_read(input logic [5:0] a, input int unsigned dc, input logic [7:0] d);
    issue(1'b0, a, 8'h00);
`ifdef ULPI_REG_READ_EN
    cmd_phase(1'b0, a, dc);
    chk("turn_noop", ulpi_data_o, 8'h00);
    ulpi_dir = 1'b1;
    #1;
    chk("turn_oe_drop", {7'd0, ulpi_data_oe}, 8'd0);
    step();
    ulpi_data_i = d;
    step();
    ulpi_data_i = ~d;
    chk("rd_no_stp", {7'd0, ulpi_stp}, 8'd0);
    step();
    ulpi_dir = 1'b0;
    step();
    model_rdata = d;
    check_resp(1'b0);
`else
    chk("rd_off_noop", ulpi_data_o, 8'h00);
    chk("rd_off_stp", {7'd0, ulpi_stp}, 8'd0);
    check_resp(1'b1);
`endif
  endtask

  task automatic do_abort_wdata(input logic [5:0] a, input logic [7:0] d,
                                input int unsigned dc, input int unsigned hold);
    issue(1'b1, a, d);
    cmd_phase(1'b1, a, dc);
    chk("abort_wdata_byte", ulpi_data_o, d);
    ulpi_dir = 1'b1;
    #1;
    chk("abort_oe_drop", {7'd0, ulpi_data_oe}, 8'd0);
    for (int unsigned i = 0; i <= hold; i++) begin
      step();
      chk("abort_no_stp", {7'd0, ulpi_stp}, 8'd0);
      chk("abort_no_resp", {7'd0, resp_valid}, 8'd0);
    end
    ulpi_dir = 1'b0;
    step();
    check_resp(1'b1);
  endtask

  initial begin
    rst = 1'b1; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk_ulpi);
    step();
    chk("rst_oe", {7'd0, ulpi_data_oe}, 8'd0);
    chk("rst_data", ulpi_data_o, 8'h00);
    chk("rst_stp", {7'd0, ulpi_stp}, 8'd0);
    chk("rst_ready", {7'd0, req_ready}, 8'd0);
    chk("rst_resp_valid", {7'd0, resp_valid}, 8'd0);
    chk("rst_resp_err", {7'd0, resp_err}, 8'd0);
    chk("rst_rdata", resp_rdata, 8'h00);

    // Request held while the PHY owns the bus, then through the first dir-low cycle.
    ulpi_dir = 1'b1; rst = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h0A; req_wdata = 8'h55;
    step();
    chk("dir_high_ready", {7'd0, req_ready}, 8'd0);
    step();
    chk("dir_high_oe", {7'd0, ulpi_data_oe}, 8'd0);
    ulpi_dir = 1'b0;
    #1;
    chk("dir_fall_ready", {7'd0, req_ready}, 8'd0);
    step();
    chk("owned_noop", ulpi_data_o, 8'h00);

    do_write(6'h0A, 8'h55, 1, 0);
    do_read(6'h16, 0, 8'h3C);
    do_abort_wdata(6'h21, 8'hA7, 0, 1);

    // nxt never arrives: TMO cycles of CMD, then stp with an error response.
    issue(1'b1, 6'h3F, 8'h99);
    for (int unsigned i = 0; i < TMO; i++) begin
      chk("tmo_cmd", ulpi_data_o, cmd_byte(1'b1, 6'h3F));
      chk("tmo_stp_low", {7'd0, ulpi_stp}, 8'd0);
      step();
    end
    chk("tmo_stp", {7'd0, ulpi_stp}, 8'd1);
    step();
    check_resp(1'b1);

    // dir and nxt together in CMD of a write: treated as abort.
    issue(1'b1, 6'h05, 8'h11);
    ulpi_nxt = 1'b1; ulpi_dir = 1'b1;
    #1;
    chk("dirnxt_oe", {7'd0, ulpi_data_oe}, 8'd0);
    step();
    ulpi_nxt = 1'b0;
    chk("dirnxt_no_stp", {7'd0, ulpi_stp}, 8'd0);
    ulpi_dir = 1'b0;
    step();
    check_resp(1'b1);

    for (int n = 0; n < 16; n++) begin
      logic [5:0] a;
      logic [7:0] d;
      a = 6'($urandom_range(0, 63));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: do_write(a, d, $urandom_range(0, TMO - 2), $urandom_range(0, TMO - 2));
        1: do_read(a, $urandom_range(0, TMO - 2), d);
        default: do_abort_wdata(a, d, $urandom_range(0, TMO - 2), $urandom_range(0, 2));
      endcase
    end

    // Reset in the middle of a write data phase.
    issue(1'b1, 6'h12, 8'hC3);
    cmd_phase(1'b1, 6'h12, 0);
    chk("pre_rst_wdata", ulpi_data_o, 8'hC3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_oe", {7'd0, ulpi_data_oe}, 8'd0);
    chk("mid_rst_stp", {7'd0, ulpi_stp}, 8'd0);
    chk("mid_rst_resp", {7'd0, resp_valid}, 8'd0);
    chk("mid_rst_data", ulpi_data_o, 8'h00);
    chk("mid_rst_ready", {7'd0, req_ready}, 8'd0);
    step();
    chk("post_rst_ready", {7'd0, req_ready}, 8'd1);
    model_rdata = 8'h00;
    chk("post_rst_rdata", resp_rdata, model_rdata);
    do_write(6'h01, 8'h7E, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
